// File: rtl/alu_op_control_sequencer.sv
// Control-step sequencer for fetch plus a 3-register ALU instruction (T0..T5, read wait TW).
// Optional single-step build: define STEP_MODE_EN to add i_step and gate every non-IDLE transition.
module alu_op_control_sequencer #(
    parameter int DATA_W     = 32,
    parameter int OPC_W      = 5,
    parameter int RIDX_W     = 4,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                      i_clock,
    input  logic                      i_clearN,
    input  logic                      i_run,
    input  logic                      i_memReady,
`ifdef STEP_MODE_EN
    input  logic                      i_step,
`endif
    input  logic [DATA_W-1:0]         i_ir,
    output logic                      o_pcOut,
    output logic                      o_zlowOut,
    output logic                      o_mdrOut,
    output logic                      o_marIn,
    output logic                      o_zIn,
    output logic                      o_pcIn,
    output logic                      o_mdrIn,
    output logic                      o_irIn,
    output logic                      o_yIn,
    output logic                      o_incPc,
    output logic                      o_read,
    output logic [(2**RIDX_W)-1:0]    o_rOut,
    output logic [(2**RIDX_W)-1:0]    o_rIn,
    output logic [1:0]                o_aluOp,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_illegal,
    output logic                      o_fault
);

    localparam int NUM_REGS = 2**RIDX_W;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] T0   = 3'd1;
    localparam logic [2:0] T1   = 3'd2;
    localparam logic [2:0] TW   = 3'd3;
    localparam logic [2:0] T2   = 3'd4;
    localparam logic [2:0] T3   = 3'd5;
    localparam logic [2:0] T4   = 3'd6;
    localparam logic [2:0] T5   = 3'd7;

    logic [2:0]          r_state;
    logic [2:0]          w_nextState;
    logic [7:0]          r_count;
    logic [1:0]          r_aluOp;
    logic [RIDX_W-1:0]   r_ra;
    logic [RIDX_W-1:0]   r_rc;

    logic [OPC_W-1:0]    w_op;
    logic [RIDX_W-1:0]   w_ra;
    logic [RIDX_W-1:0]   w_rb;
    logic [RIDX_W-1:0]   w_rc;
    logic                w_legal;
    logic [1:0]          w_aluOp;
    logic                w_adv;
    logic                w_timeout;

`ifdef STEP_MODE_EN
    assign w_adv = i_step;
`else
    assign w_adv = 1'b1;
`endif

    assign w_op = i_ir[DATA_W-1 -: OPC_W];
    assign w_ra = i_ir[DATA_W-OPC_W-1 -: RIDX_W];
    assign w_rb = i_ir[DATA_W-OPC_W-RIDX_W-1 -: RIDX_W];
    assign w_rc = i_ir[DATA_W-OPC_W-2*RIDX_W-1 -: RIDX_W];

    generate
        if (DATA_W > OPC_W + 3*RIDX_W) begin : g_unusedBits
            logic w_unusedIr;
            assign w_unusedIr = ^i_ir[DATA_W-OPC_W-3*RIDX_W-1:0];
        end
    endgenerate

    always_comb begin
        w_legal = 1'b1;
        w_aluOp = 2'b00;
        case (w_op)
            OPC_W'(3):  w_aluOp = 2'b00;
            OPC_W'(4):  w_aluOp = 2'b01;
            OPC_W'(9):  w_aluOp = 2'b10;
            OPC_W'(10): w_aluOp = 2'b11;
            default:    w_legal = 1'b0;
        endcase
    end

    // Last permitted wait cycle: count holds the number of TW cycles already spent.
    assign w_timeout = (r_state == TW) && !i_memReady && (r_count == 8'(RD_TIMEOUT - 1));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (i_run) w_nextState = T0;
            T0:   if (w_adv) w_nextState = T1;
            T1:   if (w_adv) w_nextState = i_memReady ? T2 : TW;
            TW: begin
                if (w_adv) begin
                    if (i_memReady)     w_nextState = T2;
                    else if (w_timeout) w_nextState = IDLE;
                end
            end
            T2:   if (w_adv) w_nextState = T3;
            T3:   if (w_adv) w_nextState = w_legal ? T4 : IDLE;
            T4:   if (w_adv) w_nextState = T5;
            T5:   if (w_adv) w_nextState = i_run ? T0 : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_clearN) begin
        if (!i_clearN) begin
            r_state <= IDLE;
            r_count <= '0;
            r_aluOp <= '0;
            r_ra    <= '0;
            r_rc    <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == T1)
                r_count <= '0;
            else if (r_state == TW && w_adv)
                r_count <= r_count + 8'd1;
            if (r_state == T3 && w_adv) begin
                r_aluOp <= w_aluOp;
                r_ra    <= w_ra;
                r_rc    <= w_rc;
            end
        end
    end

    always_comb begin
        o_pcOut   = 1'b0;
        o_zlowOut = 1'b0;
        o_mdrOut  = 1'b0;
        o_marIn   = 1'b0;
        o_zIn     = 1'b0;
        o_pcIn    = 1'b0;
        o_mdrIn   = 1'b0;
        o_irIn    = 1'b0;
        o_yIn     = 1'b0;
        o_incPc   = 1'b0;
        o_read    = 1'b0;
        o_rOut    = '0;
        o_rIn     = '0;
        o_aluOp   = 2'b00;
        o_done    = 1'b0;
        o_illegal = 1'b0;
        o_fault   = 1'b0;
        o_busy    = (r_state != IDLE);
        case (r_state)
            T0: begin
                o_pcOut = 1'b1;
                o_marIn = 1'b1;
                o_incPc = 1'b1;
                o_zIn   = 1'b1;
            end
            T1: begin
                o_zlowOut = 1'b1;
                o_pcIn    = 1'b1;
                o_read    = 1'b1;
                o_mdrIn   = 1'b1;
            end
            TW: begin
                o_read  = 1'b1;
                o_mdrIn = 1'b1;
                o_fault = w_timeout && w_adv;
            end
            T2: begin
                o_mdrOut = 1'b1;
                o_irIn   = 1'b1;
            end
            T3: begin
                if (w_legal) begin
                    o_rOut = NUM_REGS'(1) << w_rb;
                    o_yIn  = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            T4: begin
                o_rOut  = NUM_REGS'(1) << r_rc;
                o_zIn   = 1'b1;
                o_aluOp = r_aluOp;
            end
            T5: begin
                o_zlowOut = 1'b1;
                o_rIn     = NUM_REGS'(1) << r_ra;
                o_done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
